// File: rtl/priority_event_scheduler_if.sv
// Event/mask inputs and valid-ready dispatch bus of the priority event scheduler.
// The master drives events, mask and ready. The slave (the scheduler) drives the offer and the status.
interface priority_event_scheduler_if #(
  parameter int WIDTH = 32
);
  localparam int IW = $clog2(WIDTH);

  logic [WIDTH-1:0] i_event;
  logic [WIDTH-1:0] i_mask;
  logic             i_ready;
  logic             o_valid;
  logic [IW-1:0]    o_index;
  logic [WIDTH-1:0] o_pending;
  logic [15:0]      o_coalesce_cnt;

  modport master (
    output i_event, i_mask, i_ready,
    input  o_valid, o_index, o_pending, o_coalesce_cnt
  );

  modport slave (
    input  i_event, i_mask, i_ready,
    output o_valid, o_index, o_pending, o_coalesce_cnt
  );
endinterface

// File: rtl/priority_event_scheduler.sv
// Latches per-source events and offers the highest enabled pending index. An offer appears two edges after the event.
// Under backpressure the offer is held until accepted, with no preemption. Acceptance costs one idle cycle.
module priority_event_scheduler #(
  parameter int WIDTH         = 32,
  parameter     INSTANCE_NAME = ""
) (
  input logic                       i_clk,
  input logic                       i_rst,
  priority_event_scheduler_if.slave bus
);
  localparam int IW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, OFFER = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    index_q, index_d, sel_idx;
  logic [WIDTH-1:0] pending_q, pending_d, sel_vec, clr_vec, dup_vec;
  logic [15:0]      cnt_q, cnt_d;
  logic [16:0]      cnt_sum;
  logic [CW-1:0]    dup_cnt;
  logic             accept;

  assign sel_vec = pending_q & bus.i_mask;

  // Find-last-set: later iterations overwrite, so the highest index wins.
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sel_vec[i]) sel_idx = IW'(i);
    end
  end

  assign accept    = (state_q == OFFER) && bus.i_ready;
  assign clr_vec   = accept ? (WIDTH'(1) << index_q) : '0;
  assign pending_d = (pending_q & ~clr_vec) | bus.i_event;
  // A re-arm of the bit being accepted is a fresh event, not a coalesce.
  assign dup_vec   = bus.i_event & pending_q & ~clr_vec;

  always_comb begin
    dup_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      dup_cnt = dup_cnt + CW'(dup_vec[i]);
    end
  end

  assign cnt_sum = {1'b0, cnt_q} + 17'(dup_cnt);
  assign cnt_d   = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    case (state_q)
      IDLE: begin
        if (|sel_vec) begin
          state_d = OFFER;
          index_d = sel_idx;
        end
      end
      OFFER: begin
        if (bus.i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      index_q   <= '0;
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.o_valid        = (state_q == OFFER);
  assign bus.o_index        = index_q;
  assign bus.o_pending      = pending_q;
  assign bus.o_coalesce_cnt = cnt_q;
endmodule

// File: tb/tb_priority_event_scheduler.sv
// Scenario-per-task bench for priority_event_scheduler. Expected offer order is queued at stimulus time.
// Expected offers are popped from the queue when the scheduler offers.
module tb_priority_event_scheduler;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   exp_q[$];

  priority_event_scheduler_if #(.WIDTH(WIDTH)) bus ();

  priority_event_scheduler #(.WIDTH(WIDTH), .INSTANCE_NAME("tb")) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    bus.i_event = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.i_event = '0; bus.i_mask = '0; bus.i_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.o_valid); end
    n_cmp++; if (bus.o_index !== 5'd0) begin n_fail++; $display("FAIL reset_index: got %0d want 0", bus.o_index); end
    n_cmp++; if (bus.o_pending !== 32'h0) begin n_fail++; $display("FAIL reset_pending: got %h want 0", bus.o_pending); end
    n_cmp++; if (bus.o_coalesce_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_cnt: got %h want 0", bus.o_coalesce_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int e;
    do_reset();
    bus.i_mask = '1; bus.i_ready = 1'b1;
    bus.i_event = 32'h0000_0010; exp_q.push_back(4);
    @(negedge clk);
    bus.i_event = '0;
    n_cmp++; if (bus.o_pending !== 32'h10) begin n_fail++; $display("FAIL single_pending: got %h want 10", bus.o_pending); end
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL single_early: got %b want 0", bus.o_valid); end
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", bus.o_valid); end
    n_cmp++; if (bus.o_index !== 5'(e)) begin n_fail++; $display("FAIL single_index: got %0d want %0d", bus.o_index, e); end
    @(negedge clk);
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL single_drop: got %b want 0", bus.o_valid); end
    n_cmp++; if (bus.o_pending !== 32'h0) begin n_fail++; $display("FAIL single_clear: got %h want 0", bus.o_pending); end
  endtask

  task automatic test_priority();
    int e;
    do_reset();
    bus.i_mask = '1; bus.i_ready = 1'b1;
    bus.i_event = 32'h8000_0001; exp_q.push_back(31); exp_q.push_back(0);
    @(negedge clk);
    bus.i_event = '0;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      if (bus.o_valid) begin
        e = exp_q.pop_front();
        n_cmp++; if (bus.o_index !== 5'(e)) begin n_fail++; $display("FAIL prio_order: got %0d want %0d", bus.o_index, e); end
      end
      @(negedge clk);
    end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL prio_timeout: got %0d offers missing want 0", exp_q.size()); exp_q.delete(); end
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL prio_idle: got %b want 0", bus.o_valid); end
    n_cmp++; if (bus.o_pending !== 32'h0) begin n_fail++; $display("FAIL prio_pending: got %h want 0", bus.o_pending); end
    n_cmp++; if (bus.o_coalesce_cnt !== 16'h0) begin n_fail++; $display("FAIL prio_cnt: got %h want 0", bus.o_coalesce_cnt); end
  endtask

  task automatic test_backpressure();
    int e;
    do_reset();
    bus.i_mask = '1; bus.i_ready = 1'b0;
    bus.i_event = 32'h1 << 3; exp_q.push_back(3);
    @(negedge clk);
    bus.i_event = '0;
    for (int c = 0; c < 10 && !bus.o_valid; c++) @(negedge clk);
    bus.i_event = 32'h1 << 20; exp_q.push_back(20);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.i_event = '0;
      n_cmp++; if (bus.o_valid !== 1'b1 || bus.o_index !== 5'(exp_q[0])) begin
        n_fail++; $display("FAIL bp_hold: got valid %b index %0d want valid 1 index %0d", bus.o_valid, bus.o_index, exp_q[0]);
      end
    end
    bus.i_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      if (bus.o_valid) begin
        e = exp_q.pop_front();
        n_cmp++; if (bus.o_index !== 5'(e)) begin n_fail++; $display("FAIL bp_order: got %0d want %0d", bus.o_index, e); end
      end
      @(negedge clk);
    end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_timeout: got %0d offers missing want 0", exp_q.size()); exp_q.delete(); end
    n_cmp++; if (bus.o_pending !== 32'h0) begin n_fail++; $display("FAIL bp_pending: got %h want 0", bus.o_pending); end
  endtask

  task automatic test_coalesce();
    int e;
    logic [15:0] exp_cnt;
    do_reset();
    exp_cnt = 16'd0;
    bus.i_mask = '0; bus.i_ready = 1'b0;
    for (int p = 0; p < 3; p++) begin
      bus.i_event = 32'h1 << 5;
      if (p > 0) exp_cnt = exp_cnt + 16'd1;
      @(negedge clk);
      bus.i_event = '0;
      @(negedge clk);
    end
    n_cmp++; if (bus.o_coalesce_cnt !== exp_cnt) begin n_fail++; $display("FAIL coal_cnt: got %0d want %0d", bus.o_coalesce_cnt, exp_cnt); end
    n_cmp++; if (bus.o_pending !== 32'h20) begin n_fail++; $display("FAIL coal_pending: got %h want 20", bus.o_pending); end
    bus.i_mask = '1; bus.i_ready = 1'b1;
    exp_q.push_back(5); exp_q.push_back(5);
    for (int c = 0; c < 10 && !bus.o_valid; c++) @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++; if (bus.o_valid !== 1'b1 || bus.o_index !== 5'(e)) begin n_fail++; $display("FAIL rearm_offer1: got valid %b index %0d want valid 1 index %0d", bus.o_valid, bus.o_index, e); end
    bus.i_event = 32'h1 << 5;
    @(negedge clk);
    bus.i_event = '0;
    n_cmp++; if (bus.o_pending !== 32'h20) begin n_fail++; $display("FAIL rearm_pending: got %h want 20", bus.o_pending); end
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL rearm_gap: got %b want 0", bus.o_valid); end
    n_cmp++; if (bus.o_coalesce_cnt !== exp_cnt) begin n_fail++; $display("FAIL rearm_cnt: got %0d want %0d", bus.o_coalesce_cnt, exp_cnt); end
    for (int c = 0; c < 10 && !bus.o_valid; c++) @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++; if (bus.o_valid !== 1'b1 || bus.o_index !== 5'(e)) begin n_fail++; $display("FAIL rearm_offer2: got valid %b index %0d want valid 1 index %0d", bus.o_valid, bus.o_index, e); end
    @(negedge clk);
    n_cmp++; if (bus.o_pending !== 32'h0) begin n_fail++; $display("FAIL rearm_clear: got %h want 0", bus.o_pending); end
  endtask

  task automatic test_mask_reset();
    int e;
    do_reset();
    bus.i_mask = '0; bus.i_ready = 1'b0;
    bus.i_event = (32'h1 << 7) | (32'h1 << 9);
    @(negedge clk);
    bus.i_event = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL mask_novalid: got %b want 0", bus.o_valid); end
    n_cmp++; if (bus.o_pending !== 32'h280) begin n_fail++; $display("FAIL mask_pending: got %h want 280", bus.o_pending); end
    bus.i_mask = 32'h1 << 7; exp_q.push_back(7);
    @(negedge clk);
    e = exp_q.pop_front();
    n_cmp++; if (bus.o_valid !== 1'b1 || bus.o_index !== 5'(e)) begin n_fail++; $display("FAIL mask_offer: got valid %b index %0d want valid 1 index %0d", bus.o_valid, bus.o_index, e); end
    bus.i_mask = '0;
    @(negedge clk);
    n_cmp++; if (bus.o_valid !== 1'b1 || bus.o_index !== 5'd7) begin n_fail++; $display("FAIL mask_nowithdraw: got valid %b index %0d want valid 1 index 7", bus.o_valid, bus.o_index); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b want 0", bus.o_valid); end
    n_cmp++; if (bus.o_pending !== 32'h0) begin n_fail++; $display("FAIL arst_pending: got %h want 0", bus.o_pending); end
    n_cmp++; if (bus.o_index !== 5'd0) begin n_fail++; $display("FAIL arst_index: got %0d want 0", bus.o_index); end
    @(negedge clk);
    rst = 1'b0; bus.i_mask = '1; bus.i_ready = 1'b1;
    bus.i_event = 32'h1 << 2; exp_q.push_back(2);
    @(negedge clk);
    bus.i_event = '0;
    n_cmp++; if (bus.o_pending !== 32'h4) begin n_fail++; $display("FAIL post_rst_sample: got %h want 4", bus.o_pending); end
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
      if (bus.o_valid) begin
        e = exp_q.pop_front();
        n_cmp++; if (bus.o_index !== 5'(e)) begin n_fail++; $display("FAIL post_rst_offer: got %0d want %0d", bus.o_index, e); end
      end
      @(negedge clk);
    end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL post_rst_timeout: got %0d offers missing want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_saturate();
    do_reset();
    bus.i_mask = '0; bus.i_ready = 1'b0;
    bus.i_event = '1;
    // First edge only sets pending; each later edge coalesces all 32 sources.
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.o_coalesce_cnt !== 16'd64) begin n_fail++; $display("FAIL sat_partial: got %0d want 64", bus.o_coalesce_cnt); end
    repeat (2045) @(negedge clk);
    n_cmp++; if (bus.o_coalesce_cnt !== 16'hFFE0) begin n_fail++; $display("FAIL sat_near: got %h want ffe0", bus.o_coalesce_cnt); end
    @(negedge clk);
    n_cmp++; if (bus.o_coalesce_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_clip: got %h want ffff", bus.o_coalesce_cnt); end
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.o_coalesce_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h want ffff", bus.o_coalesce_cnt); end
    bus.i_event = '0;
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_backpressure();
    test_coalesce();
    test_mask_reset();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/priority_event_scheduler.md
PRIORITY_EVENT_SCHEDULER -- requirements
Module: priority_event_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 32: number of event sources, legal range 2..64.
REQ-002 SHALL have parameter INSTANCE_NAME, default "": debug tag with no functional effect.
REQ-003 SHALL have port i_clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst, input, 1: asynchronous active-high reset.
REQ-005 SHALL have port i_event, input, WIDTH: per-source set pulses, sampled every cycle.
REQ-006 SHALL have port i_mask, input, WIDTH: per-source enable, 1 = eligible for dispatch.
REQ-007 SHALL have port o_valid, output, 1: dispatch offer valid.
REQ-008 SHALL have port i_ready, input, 1: consumer accepts the offer.
REQ-009 SHALL have port o_index, output, $clog2(WIDTH): source number being offered.
REQ-010 SHALL have port o_pending, output, WIDTH: registered pending-event vector.
REQ-011 SHALL have port o_coalesce_cnt, output, 16: saturating count of events that arrived while already pending.

Function
REQ-012 SHALL hold pending[i], set by i_event[i] and cleared only by acceptance of index i; a set in the same cycle as a clear wins, so the bit stays 1.
REQ-013 SHALL select the highest set index of (pending & i_mask), found by a find-last-set search; lower indices lose.
REQ-014 SHALL implement a two-state FSM: IDLE and OFFER.
REQ-015 IDLE: if (pending & i_mask) is nonzero, SHALL register the selected index into o_index, assert o_valid and go to OFFER on the next edge; otherwise SHALL stay in IDLE with o_valid = 0.
REQ-016 OFFER: SHALL hold o_valid = 1 and o_index stable until o_valid & i_ready is sampled; a higher-priority arrival SHALL NOT preempt the offer.
REQ-017 OFFER: on acceptance, SHALL clear pending[o_index], drop o_valid and return to IDLE on the same edge, so offers have at most one per two cycles throughput.
REQ-018 OFFER: deassertion of i_mask[o_index] SHALL NOT withdraw the offer.
REQ-019 Latency: an event sampled at edge k into an empty IDLE scheduler SHALL give pending at k and o_valid = 1 after edge k+1.
REQ-020 o_coalesce_cnt SHALL increment by popcount(i_event & pending_before_update), excluding the bit being cleared that cycle, and SHALL saturate at 0xFFFF without wrapping.
REQ-021 Events on masked sources SHALL still set pending and SHALL be offered once unmasked.
REQ-022 All outputs SHALL be registered.

Reset
REQ-023 i_rst SHALL asynchronously force state = IDLE, o_valid = 0, o_index = 0, o_pending = 0 and o_coalesce_cnt = 0.
REQ-024 Reset asserted during OFFER SHALL discard the offer and all pending events.
REQ-025 After i_rst deasserts, events SHALL be sampled from the first rising edge.

Verification
REQ-026 Single event: i_event = 0x0000_0010 for one cycle, i_mask all-ones, i_ready = 1 -> o_valid rises 2 cycles after the event cycle with o_index = 4 for one cycle; o_pending then returns to 0.
REQ-027 Priority: i_event = 0x8000_0001 pulsed, i_ready = 1 -> offers o_index = 31, then o_index = 0, then idle; o_coalesce_cnt = 0.
REQ-028 Backpressure and no preemption: i_ready = 0, event 3 offered, then event 20 arrives -> o_index stays 3 until i_ready = 1; next offer is 20.
REQ-029 Coalesce and same-cycle re-arm: bit 5 pending, i_event[5] pulsed twice -> o_coalesce_cnt = 2; event 5 re-pulsed in its accept cycle -> pending[5] stays 1 and index 5 is re-offered.
REQ-030 Mask and reset: i_mask = 0, event 7 -> no o_valid and o_pending[7] = 1; set i_mask[7] -> offer 7; assert i_rst mid-offer -> o_valid = 0 and o_pending = 0 asynchronously.
